// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: owner encoding and default sizing.
package ram_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 4;

    // Owner / grant encoding, also used for the read-return tag.
    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    // Squeeze the starvation limit into the 4-bit counter's legal range 1..15.
    function automatic logic [3:0] clamp_limit(input int v);
        if (v < 1) begin
            return 4'd1;
        end else if (v > 15) begin
            return 4'd15;
        end
        return 4'(v);
    endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// DMA starvation counter: counts cycles a DMA request waits, holds at the limit.
module arb_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] count,
    output logic       at_limit
);

    logic [3:0] r_count;

    // Count waiting cycles; clear wins over increment, saturate at limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (clr) begin
            r_count <= 4'd0;
        end else if (inc && (r_count < limit)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == limit);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the CPU MEM stage and a DMA/loader port.
// CPU has priority until a waiting DMA request reaches MAX_WAIT cycles.
//
//   state    | meaning
//   ---------+--------------------------------------------
//   OWN_IDLE | no RAM access granted last cycle
//   OWN_CPU  | CPU was granted the RAM last cycle
//   OWN_DMA  | DMA was granted the RAM last cycle
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner,
    output logic              err
);

    localparam logic [3:0] WAIT_LIMIT = clamp_limit(MAX_WAIT);

    logic [1:0] r_state;
    logic [1:0] r_rtag;
    logic       r_err;

    logic       w_cpu_req;
    logic       w_cpu_we;
    logic       w_dma_wins;
    logic [1:0] w_grant;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic       w_wait_inc;
    logic       w_wait_clr;
    logic [3:0] w_wait_cnt;
    logic       w_at_limit;
    logic [1:0] w_rtag_nxt;

    // A simultaneous load+store is treated as a store; err flags it.
    assign w_cpu_req  = cpu_rd | cpu_wr;
    assign w_cpu_we   = cpu_wr;
    assign w_dma_wins = dma_req & (~w_cpu_req | w_at_limit);

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        w_grant = OWN_IDLE;
        if (rst) begin
            if (w_dma_wins) begin
                w_grant = OWN_DMA;
            end else if (w_cpu_req) begin
                w_grant = OWN_CPU;
            end
        end
    end

    assign w_cpu_gnt = (w_grant == OWN_CPU);
    assign w_dma_gnt = (w_grant == OWN_DMA);

    // Steer the granted requester onto the RAM port.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = w_cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (w_dma_gnt) begin
            ram_en    = 1'b1;
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end
    end

    assign cpu_stall = rst & w_cpu_req & ~w_cpu_gnt;
    assign dma_gnt   = w_dma_gnt;

    // A DMA withdrawal cancels the wait just like a grant does.
    assign w_wait_inc = dma_req & ~w_dma_gnt;
    assign w_wait_clr = ~dma_req | w_dma_gnt;

    arb_wait_cnt u_wait (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_wait_inc),
        .clr      (w_wait_clr),
        .limit    (WAIT_LIMIT),
        .count    (w_wait_cnt),
        .at_limit (w_at_limit)
    );

    // Only granted reads produce a return next cycle.
    always_comb begin
        w_rtag_nxt = OWN_IDLE;
        if (w_cpu_gnt && !w_cpu_we) begin
            w_rtag_nxt = OWN_CPU;
        end else if (w_dma_gnt && !dma_we) begin
            w_rtag_nxt = OWN_DMA;
        end
    end

    // Owner state, read-return tag and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OWN_IDLE;
            r_rtag  <= OWN_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_grant;
            r_rtag  <= w_rtag_nxt;
            if (cpu_rd && cpu_wr) begin
                r_err <= 1'b1;
            end
        end
    end

    // The saturating counter must never pass its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (w_wait_cnt <= WAIT_LIMIT);
        end
    end

    assign owner      = r_state;
    assign err        = r_err;
    assign cpu_rvalid = (r_rtag == OWN_CPU);
    assign dma_rvalid = (r_rtag == OWN_DMA);
    assign cpu_rdata  = ram_rdata;
    assign dma_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// compared against a cycle-level reference of the arbitration rules.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [1:0]    owner;
    logic          err;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    int            n_chk = 0;
    int            n_err = 0;

    // reference state: 0 none / 1 cpu / 2 dma
    int            m_wait;
    int            m_owner;
    int            m_ret;
    logic          m_err;
    logic [DW-1:0] m_ret_data;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait     = 0;
        m_owner    = 0;
        m_ret      = 0;
        m_err      = 1'b0;
        m_ret_data = '0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cwd, input logic dreq, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    endtask

    // Compare the current cycle against the rules, then advance the reference.
    task automatic check_cycle(input string tag, output int g);
        logic creq;
        logic exp_we;
        #1;
        creq = cpu_rd | cpu_wr;
        if (!creq && !dma_req)  g = 0;
        else if (!dma_req)      g = 1;
        else if (!creq)         g = 2;
        else                    g = (m_wait == MW) ? 2 : 1;
        exp_we = (g == 1) ? cpu_wr : (g == 2) ? dma_we : 1'b0;

        chk({tag, ".ram_en"},    32'(ram_en),     32'(g != 0));
        chk({tag, ".ram_we"},    32'(ram_we),     32'(exp_we));
        chk({tag, ".cpu_stall"}, 32'(cpu_stall),  32'(creq && g != 1));
        chk({tag, ".dma_gnt"},   32'(dma_gnt),    32'(g == 2));
        if (g == 1) chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(cpu_addr));
        if (g == 2) chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(dma_addr));
        if (g == 1 && cpu_wr) chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(cpu_wdata));
        if (g == 2 && dma_we) chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(dma_wdata));
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(m_ret == 1));
        chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(m_ret == 2));
        if (m_ret == 1) chk({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(m_ret_data));
        if (m_ret == 2) chk({tag, ".dma_rdata"}, 32'(dma_rdata), 32'(m_ret_data));
        chk({tag, ".owner"},    32'(owner),            32'(m_owner));
        chk({tag, ".err"},      32'(err),              32'(m_err));
        chk({tag, ".wait_cnt"}, 32'(dut.w_wait_cnt),   32'(m_wait));

        m_ret = 0;
        if (g == 1) begin
            if (cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
            else begin m_ret = 1; m_ret_data = ref_mem[cpu_addr]; end
        end else if (g == 2) begin
            if (dma_we) ref_mem[dma_addr] = dma_wdata;
            else begin m_ret = 2; m_ret_data = ref_mem[dma_addr]; end
        end
        if (dma_req && g != 2) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else                   m_wait = 0;
        if (cpu_rd && cpu_wr) m_err = 1'b1;
        m_owner = g;
    endtask

    initial begin : main
        int   g;
        logic d_pend, d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic c_rd, c_wr;
        int   r;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 16'h0101) ^ 16'hA5A5;
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
        model_reset();

        // requests active while in reset: everything must stay quiet
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'h1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h44; dma_wdata = 16'h2222;
        #3;
        chk("rst.ram_en",    32'(ram_en),    32'(0));
        chk("rst.ram_we",    32'(ram_we),    32'(0));
        chk("rst.dma_gnt",   32'(dma_gnt),   32'(0));
        chk("rst.cpu_stall", 32'(cpu_stall), 32'(0));
        chk("rst.owner",     32'(owner),     32'(0));
        chk("rst.rvalid",    32'({cpu_rvalid, dma_rvalid}), 32'(0));
        chk("rst.err",       32'(err),       32'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // CPU-only read of 0xBEEF
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
        check_cycle("cpu_rd", g);
        chk("cpu_rd.en_we", 32'({ram_en, ram_we}), 32'(2'b10));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("cpu_rd_ret", g);
        chk("cpu_rd_ret.data", 32'(cpu_rdata), 32'(16'hBEEF));

        // starvation: CPU store held, DMA read waits MAX_WAIT cycles
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 8'h20, 16'h5555, 1, 0, 8'h30, 0);
            check_cycle("starve", g);
            chk("starve.gnt_cycle", 32'(dma_gnt), 32'(i == MW));
        end
        drive(0, 1, 8'h20, 16'h5555, 0, 0, 0, 0);
        check_cycle("starve_ret", g);
        chk("starve_ret.dma_rvalid", 32'(dma_rvalid), 32'(1));
        chk("starve_ret.wait0",      32'(dut.w_wait_cnt), 32'(0));

        // alternating reads: CPU then DMA, returned in grant order
        drive(1, 0, 8'h01, 0, 0, 0, 0, 0);
        check_cycle("alt0", g);
        drive(0, 0, 0, 0, 1, 0, 8'h02, 0);
        check_cycle("alt1", g);
        chk("alt1.cpu_data", 32'(cpu_rdata), 32'(ref_mem[8'h01]));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("alt2", g);
        chk("alt2.dma_data", 32'(dma_rdata), 32'(ref_mem[8'h02]));

        // DMA cancels after waiting two cycles under CPU load
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 8'h03, 0, 1, 1, 8'h40, 16'hDEAD);
            check_cycle("cancel", g);
        end
        drive(1, 0, 8'h03, 0, 0, 0, 0, 0);
        check_cycle("cancel_drop", g);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("cancel_after", g);
        chk("cancel_after.wait0", 32'(dut.w_wait_cnt), 32'(0));

        // illegal rd+wr: performed as a write, sticky err, no return
        drive(1, 1, 8'h05, 16'h1234, 0, 0, 0, 0);
        check_cycle("illegal", g);
        drive(1, 0, 8'h05, 0, 0, 0, 0, 0);
        check_cycle("illegal_rb", g);
        chk("illegal.err", 32'(err), 32'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("illegal_ret", g);
        chk("illegal_ret.data", 32'(cpu_rdata), 32'(16'h1234));

        // reset while a CPU read is in flight
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
        check_cycle("midrst", g);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst.cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        chk("midrst.owner",      32'(owner),      32'(0));
        chk("midrst.err",        32'(err),        32'(0));
        chk("midrst.ram_en",     32'(ram_en),     32'(0));
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        check_cycle("midrst_rel", g);

        // random traffic; DMA holds its request stable until granted or cancelled
        d_pend = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int n = 0; n < 400; n++) begin
            if (!d_pend) begin
                if ($urandom_range(0, 9) < 4) begin
                    d_pend  = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = AW'($urandom_range(0, 15));
                    d_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 99) < 8) begin
                d_pend = 1'b0;
            end
            r = $urandom_range(0, 99);
            c_rd = (r >= 40 && r < 70) || r >= 97;
            c_wr = (r >= 70);
            drive(c_rd, c_wr, AW'($urandom_range(0, 15)), DW'($urandom),
                  d_pend, d_we, d_addr, d_wdata);
            check_cycle("rand", g);
            if (g == 2) d_pend = 1'b0;
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("final", g);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, RAM word address width; DATA_W, default 16, data width; MAX_WAIT, default 4, range 1..15, DMA starvation limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_rd  in  1  MEM-stage load request
- cpu_wr  in  1  MEM-stage store request
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU request not served this cycle; pipeline holds
- cpu_rvalid  out  1  CPU load data valid on cpu_rdata
- cpu_rdata  out  DATA_W  CPU load data
- dma_req  in  1  DMA/loader access request
- dma_we  in  1  DMA write (1) or read (0)
- dma_addr  in  ADDR_W  DMA word address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid on dma_rdata
- dma_rdata  out  DATA_W  DMA read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe
- owner  out  2  registered owner of previous cycle: 0 IDLE, 1 CPU, 2 DMA
- err  out  1  sticky: cpu_rd and cpu_wr seen high together

Function
REQ-003 SHALL arbitrate one RAM access per cycle; grant decision and ram_* outputs combinational from current requests, wait_cnt and state.
REQ-004 Neither requesting: ram_en=0, ram_we=0, cpu_stall=0, dma_gnt=0; next state IDLE.
REQ-005 CPU only: CPU granted; ram_en=1, ram_we=cpu_wr, ram_addr=cpu_addr, ram_wdata=cpu_wdata; cpu_stall=0; next state CPU.
REQ-006 DMA only: DMA granted; dma_gnt=1, ram_en=1, ram_we=dma_we, DMA address/data driven; next state DMA.
REQ-007 Both requesting and wait_cnt<MAX_WAIT: CPU granted, cpu_stall=0, dma_gnt=0.
REQ-008 Both requesting and wait_cnt==MAX_WAIT: DMA granted, cpu_stall=1; CPU request served next cycle if still held.
REQ-009 wait_cnt (4 bits): increments each cycle dma_req=1 and dma_gnt=0; saturates at MAX_WAIT; clears to 0 on any dma_gnt or when dma_req=0.
REQ-010 DMA handshake: transfer occurs on cycle with dma_req=1 and dma_gnt=1; DMA holds req/we/addr/wdata stable until granted; dma_req deassertion before grant cancels with no RAM effect.
REQ-011 cpu_rd and cpu_wr both high: treated as write; err set and held until reset.
REQ-012 Read return: registered 2-bit tag records owner of a granted read; following cycle asserts exactly one of cpu_rvalid/dma_rvalid for one cycle; writes produce no rvalid.
REQ-013 cpu_rdata and dma_rdata SHALL both be driven from ram_rdata; meaningful only with matching rvalid.
REQ-014 Back-to-back reads by alternating owners SHALL return data in grant order, one per cycle, no bubbles.
REQ-015 owner SHALL equal the registered state of the previous cycle's grant.

Reset
REQ-016 rst low SHALL asynchronously clear state to IDLE, wait_cnt to 0, read tag to none, err to 0; owner=0, cpu_rvalid=0, dma_rvalid=0.
REQ-017 While rst low, ram_en, ram_we, dma_gnt, cpu_stall SHALL be 0 regardless of requests.
REQ-018 Reset asserted while a read is in flight SHALL drop the return; no rvalid after release.

Structure
REQ-019 Shared package ram_arb_pkg SHALL hold the owner encoding (IDLE/CPU/DMA) and the default ADDR_W, DATA_W, MAX_WAIT constants.
REQ-020 Starvation counter SHALL be a sub-module arb_wait_cnt (inc, clr, limit in; count, at_limit out).

Verification
REQ-021 CPU-only: cpu_rd=1, addr 0x10, RAM holds 0xBEEF -> ram_en=1 ram_we=0 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF, cpu_stall=0 throughout.
REQ-022 Starvation: cpu_wr held continuously, dma_req=1 dma_we=0 from cycle 0, MAX_WAIT=4 -> dma_gnt=0 cycles 0-3, dma_gnt=1 and cpu_stall=1 cycle 4, dma_rvalid=1 cycle 5, wait_cnt=0 cycle 5.
REQ-023 Alternating reads: CPU read 0x01 cycle 0, DMA-only read 0x02 cycle 1 -> cpu_rvalid cycle 1, dma_rvalid cycle 2, data of 0x01 then 0x02.
REQ-024 Cancel: dma_req=1 for 2 cycles under CPU load, then dropped -> no ram access with dma_addr, wait_cnt=0 next cycle.
REQ-025 Illegal: cpu_rd=cpu_wr=1 at addr 0x05 wdata 0x1234 -> RAM write performed, err=1 and stays 1; no cpu_rvalid.
REQ-026 Reset mid-read: CPU read granted cycle 0, rst low during cycle 1 -> cpu_rvalid=0, owner=0, err=0 after release.
